// File: rtl/alu_secuencial_pkg.sv
// alu_pkg: opcode and FSM state types shared by the sequential ALU and its testbench.
// Contents: opcode_t (4-bit opcodes; 1010-1111 are reserved) and state_t (IDLE, DIV).
package alu_pkg;
    typedef enum logic [3:0] {
        OP_SUMA  = 4'd0,
        OP_RESTA = 4'd1,
        OP_MULT  = 4'd2,
        OP_DIV   = 4'd3,
        OP_MOD   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9
    } opcode_t;
    typedef enum logic {IDLE, DIV} state_t;
endpackage

// File: rtl/alu_secuencial_if.sv
// alu_secuencial_if: request/result bundle of the sequential ALU.
// Request: start, entrada1, entrada2, selector (master drives).
// Response: resultado, carry, cero, negativo, desbordamiento, busy, done (slave drives).
interface alu_secuencial_if #(parameter int N = 4);
    logic         start;
    logic [N-1:0] entrada1;
    logic [N-1:0] entrada2;
    logic [3:0]   selector;
    logic [N-1:0] resultado;
    logic         carry;
    logic         cero;
    logic         negativo;
    logic         desbordamiento;
    logic         busy;
    logic         done;
    modport master (
        output start, entrada1, entrada2, selector,
        input  resultado, carry, cero, negativo, desbordamiento, busy, done
    );
    modport slave (
        input  start, entrada1, entrada2, selector,
        output resultado, carry, cero, negativo, desbordamiento, busy, done
    );
endinterface

// File: rtl/alu_secuencial_divisor_iterativo.sv
// divisor_iterativo: unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), load (capture operands), dividend, divisor,
//        quotient/remainder (values after the step taken on the coming edge), fin (that step is the N-th).
module divisor_iterativo #(parameter int N = 4) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         fin
);
    localparam int CW = $clog2(N);
    logic [N-1:0]  r_q, q_q, d_q;
    logic [CW-1:0] cnt_q;
    logic [N:0]    rs, trial;
    // Outputs expose the post-step values so the owner can capture the final
    // result on the same edge that performs the last iteration.
    always_comb begin
        rs        = {r_q, q_q[N-1]};
        trial     = rs - {1'b0, d_q};
        quotient  = {q_q[N-2:0], ~trial[N]};
        remainder = trial[N] ? rs[N-1:0] : trial[N-1:0];
        fin       = cnt_q == CW'(N - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            r_q   <= '0;
            q_q   <= dividend;
            d_q   <= divisor;
            cnt_q <= '0;
        end else if (!fin) begin
            r_q   <= remainder;
            q_q   <= quotient;
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/alu_secuencial.sv
// alu_secuencial: registered N-bit ALU with start/busy/done handshake and iterative div/mod.
// Ports: clk, rst (sync, active-high), bus (alu_secuencial_if.slave: operands, opcode, result, flags, busy, done).
module alu_secuencial
    import alu_pkg::*;
#(parameter int N = 4) (
    input  logic            clk,
    input  logic            rst,
    alu_secuencial_if.slave bus
);
    state_t         state_q, state_d;
    opcode_t        op_q;
    logic           load, upd, fin, c_d, v_d;
    logic [N-1:0]   a, b, res_d, quo, rem;
    logic [N:0]     sum, dif, shl, shr;
    logic [2*N-1:0] prod;
    assign a        = bus.entrada1;
    assign b        = bus.entrada2;
    assign bus.busy = state_q == DIV;
    divisor_iterativo #(.N(N)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dividend  (a),
        .divisor   (b),
        .quotient  (quo),
        .remainder (rem),
        .fin       (fin)
    );
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        dif     = {1'b0, a} - {1'b0, b};
        prod    = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        // The extra bit catches the last bit shifted out; shifts >= width flush to 0.
        shl     = {1'b0, a} << b;
        shr     = {a, 1'b0} >> b;
        state_d = state_q;
        load    = 1'b0;
        upd     = 1'b0;
        res_d   = '0;
        c_d     = 1'b0;
        v_d     = 1'b0;
        if (state_q == DIV) begin
            if (fin) begin
                upd     = 1'b1;
                state_d = IDLE;
                res_d   = op_q == OP_DIV ? quo : rem;
            end
        end else if (bus.start) begin
            upd = 1'b1;
            case (opcode_t'(bus.selector))
                OP_SUMA: begin
                    res_d = sum[N-1:0];
                    c_d   = sum[N];
                    v_d   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
                end
                OP_RESTA: begin
                    res_d = dif[N-1:0];
                    c_d   = dif[N];
                    v_d   = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
                end
                OP_MULT: begin
                    res_d = prod[N-1:0];
                    c_d   = |prod[2*N-1:N];
                    v_d   = |prod[2*N-1:N];
                end
                OP_DIV, OP_MOD: begin
                    if (b != '0) begin
                        upd     = 1'b0;
                        load    = 1'b1;
                        state_d = DIV;
                    end else begin
                        res_d = bus.selector == OP_DIV ? '1 : a;
                        v_d   = 1'b1;
                    end
                end
                OP_AND: res_d = a & b;
                OP_OR:  res_d = a | b;
                OP_XOR: res_d = a ^ b;
                OP_SLL: begin
                    res_d = shl[N-1:0];
                    c_d   = shl[N];
                end
                OP_SRL: begin
                    res_d = shr[N:1];
                    c_d   = shr[0];
                end
                default: res_d = '0;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            op_q               <= OP_SUMA;
            bus.resultado      <= '0;
            bus.carry          <= 1'b0;
            bus.cero           <= 1'b0;
            bus.negativo       <= 1'b0;
            bus.desbordamiento <= 1'b0;
            bus.done           <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus.done <= upd;
            if (load)
                op_q <= opcode_t'(bus.selector);
            if (upd) begin
                bus.resultado      <= res_d;
                bus.carry          <= c_d;
                bus.cero           <= res_d == '0;
                bus.negativo       <= res_d[N-1];
                bus.desbordamiento <= v_d;
            end
        end
    end
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: self-checking bench for alu_secuencial against an arithmetic reference model.
module tb_alu_secuencial;
    localparam int N = 4;
    localparam int M = 1 << N;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    alu_secuencial_if #(.N(N)) bus();
    alu_secuencial #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;

    // Expected {resultado, carry, cero, negativo, desbordamiento} from plain integer arithmetic.
    function automatic logic [N+3:0] model(input int op, input int a, input int b);
        int r, c, v, sa, sb, ss;
        r = 0; c = 0; v = 0;
        sa = a >= M / 2 ? a - M : a;
        sb = b >= M / 2 ? b - M : b;
        case (op)
            0: begin r = (a + b) % M; c = int'(a + b >= M); ss = sa + sb; v = int'(ss < -M / 2 || ss >= M / 2); end
            1: begin r = (a - b + M) % M; c = int'(a < b); ss = sa - sb; v = int'(ss < -M / 2 || ss >= M / 2); end
            2: begin r = (a * b) % M; c = int'(a * b >= M); v = c; end
            3: if (b == 0) begin r = M - 1; v = 1; end else r = a / b;
            4: if (b == 0) begin r = a; v = 1; end else r = a % b;
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: begin r = a; for (int i = 0; i < b; i++) begin c = (r >> (N - 1)) & 1; r = (r << 1) % M; end end
            9: begin r = a; for (int i = 0; i < b; i++) begin c = r & 1; r = r >> 1; end end
            default: r = 0;
        endcase
        return {N'(r), c[0], r == 0, r[N-1], v[0]};
    endfunction

    function automatic bit is_iter(input int op, input int b);
        return (op == 3 || op == 4) && b != 0;
    endfunction

    // Caller sits at a negedge; returns done latency (0 = never seen) and busy cycles observed.
    task automatic run_op(input int op, input int a, input int b, output int lat, output int nb);
        bus.selector = 4'(op);
        bus.entrada1 = N'(a);
        bus.entrada2 = N'(b);
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        nb  = 0;
        for (int k = 1; k <= 3 * N + 4; k++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic logic [N+5:0] outs_all();
        return {bus.resultado, bus.carry, bus.cero, bus.negativo, bus.desbordamiento, bus.busy, bus.done};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.selector = '0;
        bus.entrada1 = '0;
        bus.entrada2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (outs_all() !== '0) begin
            n_bad++;
            $display("FAIL reset outputs got=%h exp=0", outs_all());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int tab[13][6] = '{
            '{0, 7, 9, 0, 1, 0}, '{0, 7, 1, 8, 0, 1},
            '{1, 3, 5, 14, 1, 0}, '{1, 8, 1, 7, 0, 1},
            '{2, 5, 6, 14, 1, 1}, '{2, 3, 2, 6, 0, 0},
            '{3, 13, 4, 3, 0, 0}, '{4, 13, 4, 1, 0, 0},
            '{3, 9, 0, 15, 0, 1}, '{4, 9, 0, 9, 0, 1},
            '{8, 11, 1, 6, 1, 0}, '{9, 11, 5, 0, 0, 0},
            '{12, 3, 7, 0, 0, 0}
        };
        int lat, nb, r;
        logic [N+3:0] e;
        for (int i = 0; i < 13; i++) begin
            run_op(tab[i][0], tab[i][1], tab[i][2], lat, nb);
            r = tab[i][3];
            e = {N'(r), tab[i][4][0], r == 0, r[N-1], tab[i][5][0]};
            n_cmp++;
            if ({bus.resultado, bus.carry, bus.cero, bus.negativo, bus.desbordamiento} !== e) begin
                n_bad++;
                $display("FAIL directed[%0d] outputs got=%h exp=%h", i, {bus.resultado, bus.carry, bus.cero, bus.negativo, bus.desbordamiento}, e);
            end
            n_cmp++;
            if (lat !== (is_iter(tab[i][0], tab[i][2]) ? N + 1 : 1)) begin
                n_bad++;
                $display("FAIL directed[%0d] latency got=%0d exp=%0d", i, lat, is_iter(tab[i][0], tab[i][2]) ? N + 1 : 1);
            end
            n_cmp++;
            if (nb !== (is_iter(tab[i][0], tab[i][2]) ? N : 0)) begin
                n_bad++;
                $display("FAIL directed[%0d] busy_cycles got=%0d exp=%0d", i, nb, is_iter(tab[i][0], tab[i][2]) ? N : 0);
            end
        end
    endtask

    task automatic test_random();
        int op, a, b, lat, nb;
        logic [N+3:0] e;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 15);
            a  = $urandom_range(0, M - 1);
            b  = $urandom_range(0, M - 1);
            if (i % 8 == 0) b = 0;
            run_op(op, a, b, lat, nb);
            e = model(op, a, b);
            n_cmp++;
            if ({bus.resultado, bus.carry, bus.cero, bus.negativo, bus.desbordamiento} !== e) begin
                n_bad++;
                $display("FAIL random op=%0d a=%0d b=%0d got=%h exp=%h", op, a, b, {bus.resultado, bus.carry, bus.cero, bus.negativo, bus.desbordamiento}, e);
            end
            n_cmp++;
            if (lat !== (is_iter(op, b) ? N + 1 : 1) || nb !== (is_iter(op, b) ? N : 0)) begin
                n_bad++;
                $display("FAIL random timing op=%0d b=%0d lat=%0d busy=%0d", op, b, lat, nb);
            end
        end
    endtask

    task automatic test_div_ignores_start();
        int lat = 0;
        logic [N+3:0] e;
        bus.selector = 4'd3;
        bus.entrada1 = N'(13);
        bus.entrada2 = N'(4);
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.selector = 4'd0;
        bus.entrada1 = N'(1);
        bus.entrada2 = N'(1);
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 3; k <= 3 * N + 4; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        e = model(3, 13, 4);
        n_cmp++;
        if (lat !== N + 1 || {bus.resultado, bus.carry, bus.cero, bus.negativo, bus.desbordamiento} !== e) begin
            n_bad++;
            $display("FAIL div_ignore_start lat=%0d exp=%0d got=%h exp=%h", lat, N + 1, {bus.resultado, bus.carry, bus.cero, bus.negativo, bus.desbordamiento}, e);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL div_ignore_start stray done=%b busy=%b exp=0", bus.done, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int ops[4] = '{3, 4, 0, 3};
        int as[4]  = '{14, 14, 5, 15};
        int bs[4]  = '{3, 3, 6, 1};
        int lat, nb;
        logic [N+3:0] e;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], lat, nb);
            e = model(ops[i], as[i], bs[i]);
            n_cmp++;
            if ({bus.resultado, bus.carry, bus.cero, bus.negativo, bus.desbordamiento} !== e || lat !== (is_iter(ops[i], bs[i]) ? N + 1 : 1)) begin
                n_bad++;
                $display("FAIL back_to_back[%0d] got=%h exp=%h lat=%0d", i, {bus.resultado, bus.carry, bus.cero, bus.negativo, bus.desbordamiento}, e, lat);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        int lat, nb, dones = 0;
        run_op(0, 7, 1, lat, nb);
        bus.selector = 4'd3;
        bus.entrada1 = N'(13);
        bus.entrada2 = N'(4);
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs_all() !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_div outputs got=%h exp=0", outs_all());
        end
        for (int k = 0; k < N + 3; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_div activity got=%0d exp=0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_ignores_start();
        test_back_to_back();
        test_random();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
Parametrised, registered successor of the combinational 4-bit ALU, generalised to N-bit operands with a start/busy/done handshake.
- Single-cycle ops (add, sub, mul, and, or, xor, shifts) complete with 1-cycle latency.
- Div and mod use an iterative restoring divider and take N cycles of busy time.
- Used by the lab datapath/controller as the execute unit. The controller issues one op at a time and samples results on done.

Parameters:
N, 4, operand and result width in bits (N >= 2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only when not busy
entrada1  in  N  operand A
entrada2  in  N  operand B (shift amount for shifts, unsigned)
selector  in  4  opcode
resultado  out  N  registered result
carry  out  1  carry / borrow / shifted-out bit
cero  out  1  resultado == 0
negativo  out  1  resultado[N-1]
desbordamiento  out  1  overflow / divide-by-zero
busy  out  1  divider iterating
done  out  1  one-cycle pulse: outputs updated this cycle

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Reset clears all outputs (resultado, carry, cero, negativo, desbordamiento, busy, done) to 0 and the FSM to IDLE.
- Reset mid-division aborts the operation: no done pulse is produced and outputs are zeroed.
- FSM states:
  - IDLE: start=1 latches operands and selector. Div/mod with entrada2 != 0 goes to DIV. Every other case (including divide-by-zero) computes, registers outputs, and pulses done on the next edge, then stays in IDLE.
  - DIV: busy=1 for exactly N cycles. Start is ignored and inputs are not re-sampled. On the N-th iteration edge the results are registered, done=1, busy=0, and the FSM returns to IDLE.
- Timing (start sampled in cycle 0):
  - Single-cycle ops: done in cycle 1.
  - Div/mod: busy in cycles 1..N, done in cycle N+1.
  - done=1 coexists with IDLE, so a start in the done cycle is accepted (back-to-back issue).
- Outputs hold their values between done pulses.
- Opcodes and flags:
  - 0000 add: carry = unsigned carry-out; desbordamiento = signed overflow.
  - 0001 sub (A-B): carry = borrow (A<B unsigned); desbordamiento = signed overflow.
  - 0010 mul (unsigned): resultado = low N bits of the 2N-bit product; carry = desbordamiento = (upper N bits != 0).
  - 0011 div (unsigned): resultado = quotient.
  - 0100 mod (unsigned): resultado = remainder.
  - Div/mod carry = desbordamiento = 0, except divide-by-zero: div -> all ones, mod -> entrada1, desbordamiento=1, carry=0, 1-cycle latency.
  - 0101 and, 0110 or, 0111 xor: carry = desbordamiento = 0.
  - 1000 sll, 1001 srl by amount s = entrada2: s >= N gives result 0. carry = last bit shifted out for 1 <= s <= N, else 0. desbordamiento=0.
  - 1010-1111 reserved: resultado=0, cero=1, other flags 0, latency 1.
- cero and negativo are always derived from the registered resultado.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] opcode_t: OP_SUMA, OP_RESTA, OP_MULT, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL.
  - typedef enum state_t: IDLE, DIV.
- Sub-module divisor_iterativo (param N) holds the restoring divider.
  - Inputs: clk, rst, load, dividend, divisor.
  - Outputs: quotient, remainder, fin.
  - One quotient bit per cycle, fin after N cycles.
- Top level holds the FSM, single-cycle datapath and flag logic.

Test Plan (N=4):
- add 0111+1001 -> resultado 0000, carry 1, cero 1, desbordamiento 0, done at cycle 1. Add 0111+0001 -> 1000, negativo 1, desbordamiento 1, carry 0.
- sub 0011-0101 -> 1110, carry 1, negativo 1, desbordamiento 0. Sub 1000-0001 -> 0111, desbordamiento 1.
- mul 0101*0110 (30) -> resultado 1110, carry 1, desbordamiento 1. Mul 0011*0010 -> 0110, flags 0.
- div 1101/0100 -> busy cycles 1-4, done cycle 5, resultado 0011; start re-pulsed in cycle 2 is ignored. Mod 1101%0100 -> 0001. A start in the done cycle is accepted.
- div 1001/0000 -> 1111, desbordamiento 1, done cycle 1, busy never 1. Mod 1001%0000 -> 1001, desbordamiento 1.
- sll 1011 by 1 -> 0110, carry 1. srl 1011 by 5 -> 0000, carry 0, cero 1. Reserved 1100 -> 0000, cero 1. rst asserted in cycle 2 of a div -> busy 0 next cycle, all outputs 0, no done.
